// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcode encodings, buffer state and
// opcode classification helpers.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    BufEmpty,
    BufFull
  } buf_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
                      ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the arbiter (slave).
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid_in;
  logic [NUM_REQ-1:0]    req_ready_out;
  logic [NUM_REQ*32-1:0] req_op1_in;
  logic [NUM_REQ*32-1:0] req_op2_in;
  logic [NUM_REQ*4-1:0]  req_opcode_in;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [31:0]           rsp_data_out;
  logic [ID_W-1:0]       rsp_id_out;
  logic                  rsp_err_out;

  modport master (
    output req_valid_in, req_op1_in, req_op2_in, req_opcode_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_id_out, rsp_err_out
  );

  modport slave (
    input  req_valid_in, req_op1_in, req_op2_in, req_opcode_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_data_out, rsp_id_out, rsp_err_out
  );
endinterface

// File: rtl/alu_unit.sv
// Combinational 32-bit ALU; unsupported opcodes yield zero.
module alu_unit
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  opcode,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLT:  result = {32{$signed(op1) < $signed(op2)}};
      ALU_SLTU: result = {32{op1 < op2}};
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLL:  result = op1 << op2[4:0];
      ALU_SRL:  result = op1 >> op2[4:0];
      ALU_SRA:  result = $unsigned($signed(op1) >>> op2[4:0]);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr (mod NUM_REQ) wins, one-hot.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && ((32'(ptr) + off) % NUM_REQ) == i) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a one-entry
// registered result buffer that supports same-cycle drain and refill.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  buf_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept, transfer;
  logic [PTR_W-1:0]   win_idx;
  logic [31:0]        win_op1, win_op2, alu_op2, alu_result;
  logic [3:0]         win_opcode;
  logic [31:0]        data_q;
  logic [ID_W-1:0]    id_q;
  logic               err_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (bus.req_valid_in),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_idx    = '0;
    win_op1    = '0;
    win_op2    = '0;
    win_opcode = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx    = PTR_W'(i);
        win_op1    = bus.req_op1_in[32*i +: 32];
        win_op2    = bus.req_op2_in[32*i +: 32];
        win_opcode = bus.req_opcode_in[4*i +: 4];
      end
    end
    // RISC-V shifts only honour the low five bits of the shift amount
    alu_op2 = is_shift(win_opcode) ? {27'b0, win_op2[4:0]} : win_op2;
  end

  alu_unit u_alu_unit (
    .op1    (win_op1),
    .op2    (alu_op2),
    .opcode (win_opcode),
    .result (alu_result)
  );

  assign can_accept = (state_q == BufEmpty) || bus.rsp_ready_in;
  assign transfer   = !rst && can_accept && (|grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BufEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BufEmpty: if (transfer) state_d = BufFull;
      BufFull:  if (bus.rsp_ready_in && !transfer) state_d = BufEmpty;
      default:  state_d = BufEmpty;
    endcase
  end

  always_comb begin
    bus.rsp_valid_out = (state_q == BufFull);
    bus.req_ready_out = (!rst && can_accept) ? grant : '0;
    bus.rsp_data_out  = data_q;
    bus.rsp_id_out    = id_q;
    bus.rsp_err_out   = err_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Result registers only load on a transfer so a drained buffer keeps its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (transfer) begin
        data_q <= alu_result;
        id_q   <= ID_W'(win_idx);
        err_q  <= !is_legal_op(win_opcode);
      end
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU datapath (alu_unit) between NUM_REQ requesters, e.g. the execute stage and the address-generation / branch-compare path.
- Arbitration is round-robin with a valid/ready handshake on each request port.
- Shift amounts are conditioned to RISC-V semantics before they reach the ALU.
- Each result is registered in a one-entry output buffer with backpressure and returned with the winning requester's ID.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- ID_W, 2, width of rsp_id_out; must be ≥ clog2(NUM_REQ), and at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_in  in  NUM_REQ  per-requester request valid.
- req_ready_out  out  NUM_REQ  per-requester accept; a transfer occurs when valid&ready at a rising edge.
- req_op1_in  in  NUM_REQ*32  packed operand 1; requester i is bits [32i+31:32i].
- req_op2_in  in  NUM_REQ*32  packed operand 2, same packing as operand 1.
- req_opcode_in  in  NUM_REQ*4  packed 4-bit ALU opcode.
- rsp_valid_out  out  1  output buffer holds a result.
- rsp_ready_in  in  1  consumer accepts the result.
- rsp_data_out  out  32  ALU result.
- rsp_id_out  out  ID_W  index of the requester that produced the result.
- rsp_err_out  out  1  opcode was not in the supported set.

Behaviour:
- Reset (asynchronous, active-high):
  - rsp_valid_out=0, rsp_data_out=0, rsp_id_out=0, rsp_err_out=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_out is all 0 while rst is high.
  - A transfer in flight when reset asserts is discarded and is not replayed.
- can_accept = !rsp_valid_out | rsp_ready_in. This allows same-cycle drain and refill.
- Grant (combinational):
  - Scan requesters starting at rr_ptr, ascending modulo NUM_REQ; the first with valid=1 wins.
  - At most one grant per cycle.
  - req_ready_out[g] = can_accept for the winner only. All other bits are 0.
  - req_ready_out may depend on req_valid_in. Requesters must not make valid depend on ready.
- Operand conditioning for the winner:
  - Shift opcodes (0001 SLL, 0101 SRL, 1101 SRA): op2 is replaced by {27'b0, op2[4:0]}.
  - All other opcodes: op2 passes through unchanged.
- Supported opcodes: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0111 AND, 0110 OR, 0100 XOR, 0001, 0101, 1101.
  - Any other opcode is still accepted.
  - Result is 0 (ALU default) and rsp_err_out=1 for that response.
- On a transfer at edge N (in the same edge):
  - rsp_data_out ← ALU result, rsp_id_out ← winner index, rsp_err_out ← illegal flag, rsp_valid_out ← 1.
  - rr_ptr ← (winner+1) mod NUM_REQ.
- Latency and throughput:
  - Latency is 1 cycle: the result is visible the cycle after acceptance.
  - Throughput is 1 result per cycle while rsp_ready_in=1.
- Drain without refill: rsp_valid_out ← 0 and the data/id/err registers hold their last values.
- Backpressure:
  - rsp_valid_out=1 and rsp_ready_in=0 ⇒ no grants are issued.
  - rr_ptr holds and the output registers are stable. A held response must not change.
- No valid requests: rr_ptr holds.
- Arithmetic: full 32-bit two's complement, wrap-around on overflow with no flag. SLT/SLTU results are all-ones (0xFFFF_FFFF) when true, 0 when false.
- Fairness: a continuously requesting port is granted at least once every NUM_REQ accepted transfers.
- State is the rr_ptr counter plus the one-entry output buffer; the buffer has two states, EMPTY and FULL:
  - EMPTY→FULL on a transfer.
  - FULL→FULL on drain+transfer in the same cycle.
  - FULL→EMPTY on drain with no transfer.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA).
  - An is_shift helper and an is_legal_op helper.
- Sub-modules:
  - Instantiate the existing alu_unit once as the datapath.
  - Factor the round-robin grant into rr_arbiter (parameter NUM_REQ; inputs req, ptr; output one-hot grant).

Test Plan:
- Reset mid-flight: assert rst while rsp_valid_out=1 → all outputs 0 immediately, without waiting for a clock edge. After release, rr_ptr=0: simultaneous req0/req1 grants req0 first.
- Contention: req0 ADD 5+7 and req1 SUB 3-10 both held valid, rsp_ready_in=1 → grants alternate 0,1,0,1; responses (12,id0), (0xFFFF_FFF9,id1), each one cycle after its accept.
- Backpressure: response held with rsp_ready_in=0 for 3 cycles → req_ready_out=0, rsp_data_out/id stable. Raising rsp_ready_in → same-cycle refill, and the next result follows without a bubble.
- Shift masking: SLL op1=1, op2=0x0000_0021 → result 0x2. SRA op1=0x8000_0000, op2=0x24 → 0xF800_0000.
- Compare and illegal opcode: SLT -1<1 → 0xFFFF_FFFF. SLTU 0xFFFF_FFFF<1 → 0. Opcode 1111 → data 0, rsp_err_out=1, accepted normally.
- Idle and single requester: only req1 valid for 4 cycles → 4 consecutive grants to req1, rr_ptr=0 after each. No valids → no rsp_valid_out.
